// File: rtl/dlya_meas_pkg.sv
// Shared types and helpers for the dlya delay-chain measurement block.
package dlya_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRE   = 3'd1,
        ST_SYNC   = 3'd2,
        ST_ACC    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Widest tap vector the popcount helper accepts; narrower vectors are zero-padded.
    localparam int POP_W = 64;

    function automatic int cw_f(input int ntap, input int avg_log2);
        return $clog2(ntap + 1) + avg_log2;
    endfunction

    function automatic logic [6:0] popcount_f(input logic [POP_W-1:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlya_tap_sync.sv
// Two-flop synchroniser bringing the asynchronous chain taps into the CLK domain.
module gf180mcu_fd_sc_mcu7t5v0__dlya_tap_sync #(
    parameter int NTAP = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NTAP-1:0] tap,
    output logic [NTAP-1:0] cap2
);

    logic [NTAP-1:0] cap1_q;
    logic [NTAP-1:0] cap1_d;
    logic [NTAP-1:0] cap2_q;
    logic [NTAP-1:0] cap2_d;

    // Next-state: shift the raw taps through two stages.
    always_comb begin
        cap1_d = tap;
        cap2_d = cap1_q;
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap1_q <= '0;
            cap2_q <= '0;
        end else begin
            cap1_q <= cap1_d;
            cap2_q <= cap2_d;
        end
    end

    assign cap2 = cap2_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlya_meas.sv
// Launches an edge into an external dlya chain, counts taps reached in one CLK
// period, averages over 2^AVG_LOG2 launches and hands the sum out valid/ready.
module gf180mcu_fd_sc_mcu7t5v0__dlya_meas
    import dlya_meas_pkg::*;
#(
    parameter  int NTAP       = 16,
    parameter  int AVG_LOG2   = 0,
    parameter  int SETTLE_CYC = 2,
    localparam int CW         = cw_f(NTAP, AVG_LOG2)
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            START,
    input  logic [NTAP-1:0] TAP,
    output logic            LAUNCH,
    output logic            BUSY,
    output logic [CW-1:0]   COUNT,
    output logic            VALID,
    input  logic            READY
);

    localparam int SW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam int NW = AVG_LOG2 + 1;
    localparam logic [NW-1:0] N_LAST = NW'(2 ** AVG_LOG2);

    state_e          state_q, state_d;
    logic            launch_q, launch_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [NW-1:0]   n_q, n_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [NTAP-1:0] cap2_s;
    logic [POP_W-1:0] tap_wide_s;
    logic            chain_idle_s;

    gf180mcu_fd_sc_mcu7t5v0__dlya_tap_sync #(
        .NTAP (NTAP)
    ) u_tap_sync (
        .clk   (CLK),
        .rst_n (RN),
        .tap   (TAP),
        .cap2  (cap2_s)
    );

    // Zero-pad the synchronised taps to the popcount helper width.
    always_comb begin
        tap_wide_s = '0;
        tap_wide_s[NTAP-1:0] = cap2_s;
    end

    assign chain_idle_s = (cap2_s == '0);

    // FSM next-state, accumulator and output register inputs.
    always_comb begin
        state_d  = state_q;
        launch_d = 1'b0;
        valid_d  = valid_q;
        count_d  = count_q;
        acc_d    = acc_q;
        n_d      = n_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE: begin
                if (START && chain_idle_s) begin
                    launch_d = 1'b1;
                    state_d  = ST_FIRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRE: state_d = ST_SYNC;
            ST_SYNC: state_d = ST_ACC;
            ST_ACC: begin
                // Popcount rather than leading ones so thermometer bubbles still count.
                acc_d    = acc_q + CW'(popcount_f(tap_wide_s));
                n_d      = n_q + NW'(1);
                settle_d = SW'(SETTLE_CYC);
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SW'(1);
                end else if (!chain_idle_s) begin
                    state_d = ST_SETTLE;
                end else if (n_q == N_LAST) begin
                    count_d = acc_q;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    launch_d = 1'b1;
                    state_d  = ST_FIRE;
                end
            end
            ST_DONE: begin
                if (READY) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    n_d     = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                acc_d   = '0;
                n_d     = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops LAUNCH immediately and discards any partial sum.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q  <= ST_IDLE;
            launch_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            n_q      <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            n_q      <= n_d;
            settle_q <= settle_d;
        end
    end

    assign LAUNCH = launch_q;
    assign BUSY   = busy_q;
    assign VALID  = valid_q;
    assign COUNT  = count_q;

endmodule
